// File: rtl/collide_pkg.sv
// collide_pkg: shared sizing constants and scan FSM state type for the
// collision scanner.
//   MAP_W       cells per map
//   CHUNK_W     cells evaluated per scan cycle
//   NCHUNK      chunks per map
//   IDX_W       cell index width
//   CNT_W       collision count width (holds MAP_W itself)
//   CHUNK_IDX_W chunk counter width
package collide_pkg;

  localparam int unsigned MAP_W       = 8192;
  localparam int unsigned CHUNK_W     = 64;
  localparam int unsigned NCHUNK      = MAP_W / CHUNK_W;
  localparam int unsigned IDX_W       = $clog2(MAP_W);
  localparam int unsigned CNT_W       = IDX_W + 1;
  localparam int unsigned CHUNK_IDX_W = $clog2(NCHUNK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/collide_chunk_eval.sv
// collide_chunk_eval: combinational evaluation of one conflict chunk.
//   chunk   in  CHUNK_W          conflict bits of the current chunk
//   popcnt  out log2(CHUNK_W)+1  number of set bits
//   any     out 1                at least one bit set
//   lsbPos  out log2(CHUNK_W)    position of the lowest set bit (0 if none)
module collide_chunk_eval #(
  parameter int unsigned CHUNK_W = 64
) (
  input  logic [CHUNK_W-1:0]         chunk,
  output logic [$clog2(CHUNK_W):0]   popcnt,
  output logic                       any,
  output logic [$clog2(CHUNK_W)-1:0] lsbPos
);

  localparam int unsigned POS_W = $clog2(CHUNK_W);

  logic seen;

  assign any = |chunk;

  // Written as a linear sum; synthesis re-associates it into a balanced tree.
  always_comb begin
    popcnt = '0;
    for (int unsigned i = 0; i < CHUNK_W; i++) begin
      popcnt = popcnt + (POS_W + 1)'(chunk[i]);
    end
  end

  // Priority encoder: the first set bit met from the LSB side is kept.
  always_comb begin
    lsbPos = '0;
    seen   = 1'b0;
    for (int unsigned i = 0; i < CHUNK_W; i++) begin
      if (chunk[i] && !seen) begin
        lsbPos = POS_W'(i);
        seen   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/collide_scan.sv
// collide_scan: snapshots edgeState & obstacleMap on start, then scans the
// intersection CHUNK_W cells per cycle, reporting any collision, the lowest
// colliding cell and the number of colliding cells. clearOut pulses with done
// so the upstream accumulator can begin the next pose.
//   CLK, RST     clock, asynchronous active-high reset
//   start        begin scan (IDLE only); abort cancels a running scan
//   edgeState    accumulated edge map; obstacleMap static occupancy
//   busy         scan in progress
//   done         one-cycle pulse, results valid
//   clearOut     one-cycle pulse coincident with done
//   collide      any colliding cell
//   firstHit     lowest colliding cell index
//   hitCount     number of colliding cells
module collide_scan #(
  parameter int unsigned MAP_W   = collide_pkg::MAP_W,
  parameter int unsigned CHUNK_W = collide_pkg::CHUNK_W
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic                     abort,
  input  logic [MAP_W-1:0]         edgeState,
  input  logic [MAP_W-1:0]         obstacleMap,
  output logic                     busy,
  output logic                     done,
  output logic                     clearOut,
  output logic                     collide,
  output logic [$clog2(MAP_W)-1:0] firstHit,
  output logic [$clog2(MAP_W):0]   hitCount
);

  import collide_pkg::scan_state_t;
  import collide_pkg::IDLE;
  import collide_pkg::SCAN;
  import collide_pkg::DONE;

  localparam int unsigned NCHUNK = MAP_W / CHUNK_W;
  localparam int unsigned IDX_W  = $clog2(MAP_W);
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned CI_W   = $clog2(NCHUNK);
  localparam int unsigned POS_W  = $clog2(CHUNK_W);

  scan_state_t        state;
  logic [MAP_W-1:0]   conflict;
  logic [CI_W-1:0]    chunk_idx;
  logic [IDX_W-1:0]   chunk_base;
  logic [CHUNK_W-1:0] chunk;
  logic [POS_W:0]     chunk_pop;
  logic               chunk_any;
  logic [POS_W-1:0]   chunk_pos;

  // Chunk sizes are powers of two, so base = chunk_idx * CHUNK_W is a concat.
  assign chunk_base = {chunk_idx, {POS_W{1'b0}}};
  assign chunk      = conflict[chunk_base +: CHUNK_W];

  collide_chunk_eval #(
    .CHUNK_W (CHUNK_W)
  ) u_eval (
    .chunk  (chunk),
    .popcnt (chunk_pop),
    .any    (chunk_any),
    .lsbPos (chunk_pos)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      conflict  <= '0;
      chunk_idx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      clearOut  <= 1'b0;
      collide   <= 1'b0;
      firstHit  <= '0;
      hitCount  <= '0;
    end else begin
      done     <= 1'b0;
      clearOut <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            conflict  <= edgeState & obstacleMap;
            chunk_idx <= '0;
            hitCount  <= '0;
            collide   <= 1'b0;
            firstHit  <= '0;
            busy      <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (abort) begin
            chunk_idx <= '0;
            hitCount  <= '0;
            collide   <= 1'b0;
            firstHit  <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            hitCount  <= hitCount + CNT_W'(chunk_pop);
            if (!collide && chunk_any) begin
              firstHit <= {chunk_idx, chunk_pos};
              collide  <= 1'b1;
            end
            chunk_idx <= chunk_idx + 1'b1;
            if (chunk_idx == CI_W'(NCHUNK - 1)) begin
              busy     <= 1'b0;
              done     <= 1'b1;
              clearOut <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collide_scan.sv
module tb_collide_scan;

  localparam int unsigned MAP_W = 8192;
  localparam int unsigned IDX_W = 13;
  localparam int unsigned CNT_W = 14;
  localparam int LAT   = 129;
  localparam int BUSYN = 128;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [MAP_W-1:0] edgeState = '0;
  logic [MAP_W-1:0] obstacleMap = '0;
  logic             busy, done, clearOut, collide;
  logic [IDX_W-1:0] firstHit;
  logic [CNT_W-1:0] hitCount;

  int total = 0;
  int bad   = 0;

  // Reference results
  logic exp_col;
  int   exp_first;
  int   exp_cnt;

  always #5 CLK = ~CLK;

  collide_scan #(.MAP_W(8192), .CHUNK_W(64)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .abort       (abort),
    .edgeState   (edgeState),
    .obstacleMap (obstacleMap),
    .busy        (busy),
    .done        (done),
    .clearOut    (clearOut),
    .collide     (collide),
    .firstHit    (firstHit),
    .hitCount    (hitCount)
  );

  // Behavioural model: walk all cells, keep the first and count the rest.
  task automatic model(input logic [MAP_W-1:0] e, input logic [MAP_W-1:0] o);
    exp_col = 1'b0; exp_first = 0; exp_cnt = 0;
    for (int unsigned i = 0; i < MAP_W; i++) begin
      if (e[i[12:0]] && o[i[12:0]]) begin
        if (!exp_col) begin
          exp_col = 1'b1;
          exp_first = int'(i);
        end
        exp_cnt++;
      end
    end
  endtask

  task automatic rand_map(output logic [MAP_W-1:0] m, input int pct);
    m = '0;
    for (int unsigned i = 0; i < MAP_W; i++)
      m[i[12:0]] = ($urandom_range(0, 99) < pct);
  endtask

  // Assumes it is called just after the capture edge has been sampled.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 1;
    busy_cycles = 0;
    while (!done && lat < 400) begin
      if (busy) busy_cycles++;
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic pulse_start(input bit scramble);
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    if (scramble) begin
      edgeState = {256{$urandom()}};
      obstacleMap = ~'0;
    end
  endtask

  task automatic test_reset;
    #1 RST = 1'b1;
    #1;
    total++;
    if ({busy, done, clearOut, collide, firstHit, hitCount} !== '0) begin
      bad++;
      $display("FAIL reset_async: outputs=%h required 0",
               {busy, done, clearOut, collide, firstHit, hitCount});
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;
    total++;
    if ({busy, done, clearOut, collide, firstHit, hitCount} !== '0) begin
      bad++;
      $display("FAIL reset_idle: outputs=%h required 0",
               {busy, done, clearOut, collide, firstHit, hitCount});
    end
  endtask

  task automatic test_directed;
    int lat, bc;
    for (int c = 0; c < 5; c++) begin
      edgeState = '0; obstacleMap = '0;
      case (c)
        0: obstacleMap = ~'0;
        1: begin
          edgeState[5] = 1'b1; edgeState[700] = 1'b1; edgeState[8191] = 1'b1;
          obstacleMap[700] = 1'b1; obstacleMap[8191] = 1'b1;
        end
        2: begin edgeState = ~'0; obstacleMap = ~'0; end
        3: begin edgeState = ~'0; obstacleMap[63] = 1'b1; obstacleMap[64] = 1'b1; end
        default: begin edgeState = ~'0; obstacleMap[8128] = 1'b1; end
      endcase
      model(edgeState, obstacleMap);
      pulse_start(1'b1);
      wait_done(lat, bc);
      total++;
      if (lat != LAT || bc != BUSYN || clearOut !== 1'b1) begin
        bad++;
        $display("FAIL dir%0d_timing: lat=%0d busy=%0d clearOut=%b required %0d/%0d/1",
                 c, lat, bc, clearOut, LAT, BUSYN);
      end
      total++;
      if (collide !== exp_col || firstHit !== IDX_W'(exp_first) || hitCount !== CNT_W'(exp_cnt)) begin
        bad++;
        $display("FAIL dir%0d_result: col=%b first=%0d cnt=%0d required %b/%0d/%0d",
                 c, collide, firstHit, hitCount, exp_col, exp_first, exp_cnt);
      end
      @(posedge CLK); #1;
      total++;
      if (done !== 1'b0 || clearOut !== 1'b0 || hitCount !== CNT_W'(exp_cnt)) begin
        bad++;
        $display("FAIL dir%0d_pulse_hold: done=%b clr=%b cnt=%0d required 0/0/%0d",
                 c, done, clearOut, hitCount, exp_cnt);
      end
    end
  endtask

  task automatic test_random;
    int lat, bc;
    int pe, po;
    for (int n = 0; n < 5; n++) begin
      pe = (n == 0) ? 1 : $urandom_range(1, 80);
      po = (n == 0) ? 1 : $urandom_range(0, 30);
      rand_map(edgeState, pe);
      rand_map(obstacleMap, po);
      model(edgeState, obstacleMap);
      pulse_start(1'b1);
      wait_done(lat, bc);
      total++;
      if (lat != LAT || collide !== exp_col || firstHit !== IDX_W'(exp_first) ||
          hitCount !== CNT_W'(exp_cnt)) begin
        bad++;
        $display("FAIL rand%0d: lat=%0d col=%b first=%0d cnt=%0d required %0d/%b/%0d/%0d",
                 n, lat, collide, firstHit, hitCount, LAT, exp_col, exp_first, exp_cnt);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_abort;
    int lat, bc;
    bit seen_pulse;
    logic [CNT_W-1:0] held;
    edgeState = ~'0; obstacleMap = '0;
    obstacleMap[3] = 1'b1; obstacleMap[5000] = 1'b1;
    model(edgeState, obstacleMap);
    pulse_start(1'b0);
    repeat (10) @(posedge CLK);
    #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || collide !== 1'b1 || firstHit !== 13'd3) begin
        bad++;
        $display("FAIL abort_midscan: busy=%b done=%b col=%b first=%0d required 1/0/1/3",
                 busy, done, collide, firstHit);
    end
    repeat (38) @(posedge CLK);
    #1 abort = 1'b1;
    @(posedge CLK); #1 abort = 1'b0;
    total++;
    if (busy !== 1'b0 || collide !== 1'b0 || firstHit !== '0 || hitCount !== '0) begin
      bad++;
      $display("FAIL abort_zero: busy=%b col=%b first=%0d cnt=%0d required 0/0/0/0",
               busy, collide, firstHit, hitCount);
    end
    seen_pulse = 1'b0;
    repeat (200) begin
      @(posedge CLK); #1;
      if (done || clearOut || busy) seen_pulse = 1'b1;
    end
    total++;
    if (seen_pulse) begin
      bad++;
      $display("FAIL abort_quiet: activity=1 required 0");
    end
    // Finish a scan so there are non-zero results to hold.
    pulse_start(1'b0);
    wait_done(lat, bc);
    total++;
    if (lat != LAT || collide !== exp_col || firstHit !== IDX_W'(exp_first) ||
        hitCount !== CNT_W'(exp_cnt)) begin
      bad++;
      $display("FAIL abort_rescan: lat=%0d col=%b first=%0d cnt=%0d required %0d/%b/%0d/%0d",
               lat, collide, firstHit, hitCount, LAT, exp_col, exp_first, exp_cnt);
    end
    held = hitCount;
    repeat (2) @(posedge CLK);
    #1 start = 1'b1; abort = 1'b1;
    @(posedge CLK); #1 start = 1'b0; abort = 1'b0;
    total++;
    if (busy !== 1'b0 || hitCount !== held || held !== CNT_W'(exp_cnt)) begin
      bad++;
      $display("FAIL abort_wins_idle: busy=%b cnt=%0d required 0/%0d", busy, hitCount, exp_cnt);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    edgeState = '0; obstacleMap = '0;
    edgeState[100] = 1'b1; obstacleMap[100] = 1'b1;
    pulse_start(1'b0);
    wait_done(lat, bc);
    // New maps and start presented during the DONE cycle.
    rand_map(edgeState, 30);
    rand_map(obstacleMap, 10);
    model(edgeState, obstacleMap);
    start = 1'b1;
    @(posedge CLK); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_done_ignores_start: busy=%b required 0", busy);
    end
    @(posedge CLK); #1 start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept: busy=%b required 1", busy);
    end
    wait_done(lat, bc);
    total++;
    if (lat != LAT || collide !== exp_col || firstHit !== IDX_W'(exp_first) ||
        hitCount !== CNT_W'(exp_cnt)) begin
      bad++;
      $display("FAIL b2b_result: lat=%0d col=%b first=%0d cnt=%0d required %0d/%b/%0d/%0d",
               lat, collide, firstHit, hitCount, LAT, exp_col, exp_first, exp_cnt);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_midscan_reset;
    int lat, bc;
    rand_map(edgeState, 50);
    obstacleMap = '0;
    obstacleMap[100] = 1'b1; obstacleMap[8000] = 1'b1;
    edgeState[100] = 1'b1;
    model(edgeState, obstacleMap);
    pulse_start(1'b0);
    repeat (29) @(posedge CLK);
    #1;
    total++;
    if (collide !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre: col=%b busy=%b required 1/1", collide, busy);
    end
    @(negedge CLK);
    RST = 1'b1; start = 1'b1;
    #1;
    total++;
    if ({busy, done, clearOut, collide, firstHit, hitCount} !== '0) begin
      bad++;
      $display("FAIL rst_midscan: outputs=%h required 0",
               {busy, done, clearOut, collide, firstHit, hitCount});
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_restart: busy=%b required 1", busy);
    end
    start = 1'b0;
    wait_done(lat, bc);
    total++;
    if (lat != LAT || collide !== exp_col || firstHit !== IDX_W'(exp_first) ||
        hitCount !== CNT_W'(exp_cnt)) begin
      bad++;
      $display("FAIL rst_rescan: lat=%0d col=%b first=%0d cnt=%0d required %0d/%b/%0d/%0d",
               lat, collide, firstHit, hitCount, LAT, exp_col, exp_first, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_back_to_back();
    test_midscan_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/collide_scan.md
# collide_scan

Downstream consumer of the per-pose edge accumulator. On `start` it snapshots the accumulated 8192-bit edge map and a static obstacle map, then scans their intersection in 64-bit chunks. It reports whether any cell collides, the lowest colliding cell index and the total colliding-cell count. When the scan completes it pulses `clearOut` so the upstream accumulator can begin the next pose.

## Interface
- `MAP_W`, 8192, cells per map (power of two, multiple of `CHUNK_W`)
- `CHUNK_W`, 64, cells evaluated per scan cycle (power of two)
- `CLK` in 1: the only clock; all state updates on its rising edge
- `RST` in 1: asynchronous, active-high reset
- `start` in 1: begin scan; sampled only in IDLE
- `abort` in 1: cancel an in-progress scan
- `edgeState` in MAP_W: accumulated edge map from the upstream stage
- `obstacleMap` in MAP_W: static obstacle occupancy
- `busy` out 1: scan in progress
- `done` out 1: one-cycle pulse; results valid
- `clearOut` out 1: one-cycle pulse coincident with `done`; drives the upstream accumulator clear
- `collide` out 1: at least one cell is set in both maps
- `firstHit` out log2(MAP_W) (13): lowest colliding cell index
- `hitCount` out log2(MAP_W)+1 (14): number of colliding cells

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE, `start`=1:
  - capture `conflict <= edgeState & obstacleMap` into the internal MAP_W register
  - zero `chunkIdx`, `hitCount`, `collide`, `firstHit`
  - go to SCAN
- SCAN: each cycle evaluate chunk `conflict[chunkIdx*CHUNK_W +: CHUNK_W]`:
  - `hitCount += popcount(chunk)`
  - if `collide`=0 and the chunk is non-zero: `firstHit <= chunkIdx*CHUNK_W + lowest set bit position`, `collide <= 1`
  - `chunkIdx++`
  - after chunk NCHUNK-1 (127), go to DONE
- DONE: `done`=1 and `clearOut`=1 for exactly this cycle; unconditional return to IDLE.
- Results hold their values in IDLE until the next accepted `start`.
- No collision: `collide`=0, `firstHit`=0, `hitCount`=0.
- Arithmetic: `hitCount` cannot overflow; maximum MAP_W=8192 fits 14 bits. `chunkIdx` is log2(NCHUNK) bits (7); its wrap at 127→0 is never used, because the FSM leaves SCAN first.
- `start` in SCAN or DONE: ignored, not queued.
- `abort` in SCAN:
  - go to IDLE next edge, with no `done` and no `clearOut`
  - `collide`, `firstHit`, `hitCount` are zeroed
- `abort` and `start` together in IDLE: `abort` wins; stay IDLE.
- `edgeState`/`obstacleMap` changes after the capture edge have no effect on the running scan.
- `RST` asynchronously forces:
  - IDLE
  - `busy`=0, `done`=0, `clearOut`=0, `collide`=0, `firstHit`=0, `hitCount`=0
  - `chunkIdx`=0, `conflict`=0
  
  This holds at any point, including mid-scan.

## Timing
- Capture edge k: `start` is sampled high in IDLE.
- `busy`=1 from edge k through edge k+NCHUNK (128 cycles, SCAN only); `busy`=0 in DONE and IDLE.
- Chunk i is processed at edge k+1+i; the last chunk is at edge k+128.
- `done`/`clearOut` are high for the cycle following edge k+128; outputs are valid in that cycle.
- Start-to-done latency: NCHUNK+1 edges (129).
- Earliest next `start` acceptance: edge k+130, since the DONE cycle returns to IDLE first.
- Upstream contract: the accumulator clears on the edge after `clearOut`, so the map for the next pose starts from zero.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- Shared package `collide_pkg`:
  - `MAP_W`, `CHUNK_W`
  - `NCHUNK = MAP_W/CHUNK_W`
  - `IDX_W`, `CNT_W`, `CHUNK_IDX_W`
  - state enum `scan_state_t` {IDLE, SCAN, DONE}
- Sub-module `collide_chunk_eval` (purely combinational):
  - input: CHUNK_W vector
  - outputs: `popcnt` (log2(CHUNK_W)+1 bits), `any`, `lsbPos` (log2(CHUNK_W) bits)
  - synthesised as a balanced adder tree and priority encoder
- The top level holds the FSM, the conflict register, the chunk mux and the result registers.

## Test plan
- Empty maps: `edgeState`=0, `obstacleMap`=all ones, `start` → `done` 129 edges after capture; `collide`=0, `firstHit`=0, `hitCount`=0; `clearOut` coincident with `done`.
- Single hit: edge bits {5, 700, 8191} set, obstacle bits {700, 8191} set → `collide`=1, `firstHit`=700, `hitCount`=2.
- Full overlap: both maps all ones → `hitCount`=8192, `firstHit`=0.
- Chunk boundaries: only bits 63 and 64 collide → `firstHit`=63, `hitCount`=2. Only bit 8128 collides → `firstHit`=8128.
- Abort and ignored start: `start` again at SCAN cycle 10 → ignored; `abort` at SCAN cycle 50 → IDLE, no `done`/`clearOut`, results zero; a new `start` then completes normally.
- Mid-scan reset: `RST` pulse at SCAN cycle 30 → all outputs 0 immediately (asynchronously); with `start` held high through and after release, a fresh scan starts on the first edge after release.
